// File: rtl/serdes_arith_pkg.sv
// serdes_arith_pkg: shared types and helpers for the byte-serial arithmetic unit.
package serdes_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_SUBB = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        ARMED  = 3'd2,
        CALC   = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    localparam int STAT_CARRY = 0;
    localparam int STAT_OVF   = 1;
    localparam int STAT_ZERO  = 2;

    // Subtraction is done as A + ~B + cin, so both SUB flavours invert B.
    function automatic logic is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SUBB);
    endfunction

    // Carry into the least significant slice; the chained ops reuse the sticky carry.
    function automatic logic slice_cin0(input op_e op, input logic carry);
        case (op)
            OP_ADD:  return 1'b0;
            OP_SUB:  return 1'b1;
            default: return carry;
        endcase
    endfunction

endpackage

// File: rtl/serdes_arith_unit_byte_slice_adder.sv
// byte_slice_adder: 8-bit full adder slice that also exposes the carry into bit 7,
// needed for signed-overflow detection on the most significant slice.
module byte_slice_adder
    import serdes_arith_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       msb_cin
);

    logic [7:0] low;
    logic [1:0] high;

    // Split the add at bit 7 so the carry into the sign bit is visible.
    always_comb begin
        low     = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'b0, cin};
        high    = {1'b0, a[7]} + {1'b0, b[7]} + {1'b0, low[7]};
        sum     = {high[0], low[6:0]};
        cout    = high[1];
        msb_cin = low[7];
    end

endmodule

// File: rtl/serdes_arith_unit.sv
// serdes_arith_unit: loads two WIDTH-bit operands byte-serially, computes
// ADD/SUB/ADDC/SUBB and streams back the result bytes plus a status byte.
// Build option SERDES_ARITH_FULL_ADDER_EN: single-cycle full-width CALC
// instead of one byte slice per cycle.
//
//   state  | meaning
//   LOAD_A | accepting operand A bytes, LSB first
//   LOAD_B | accepting operand B bytes, LSB first
//   ARMED  | operands loaded, waiting for start
//   CALC   | computing result slices (busy)
//   DRAIN  | streaming result bytes then status byte
module serdes_arith_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [1:0] op,
    input  logic       start,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       carry,
    output logic       overflow,
    output logic       zero
);
    import serdes_arith_pkg::*;

    localparam int BYTES = WIDTH / 8;
    localparam int CW    = $clog2(BYTES + 1);
    localparam logic [WIDTH-1:0] BYTE_MASK = WIDTH'(8'hFF);

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("serdes_arith_unit: WIDTH must be a multiple of 8 in 8..64");
    end

    state_e           state, next_state;
    logic [CW-1:0]    cnt;
    logic [CW+2:0]    sh;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
    op_e              op_q;
    logic             carry_q, ovf_q, zero_q;
    logic             last_byte, last_out, sub_op, cin0;
    logic             calc_done, z_now, cout_fin, c7_fin;
    logic [7:0]       status;

    assign sh        = {cnt, 3'b000};
    assign last_byte = (cnt == CW'(BYTES - 1));
    assign last_out  = (cnt == CW'(BYTES));
    assign sub_op    = is_sub(op_q);
    assign cin0      = slice_cin0(op_q, carry_q);

`ifndef SERDES_ARITH_FULL_ADDER_EN
    logic [7:0] s_a, s_b, s_sum;
    logic       s_cin, s_cout, s_c7, c_run, zacc;

    // Select the current byte slice of each operand and its carry-in.
    always_comb begin
        s_a   = 8'(a_reg >> sh);
        s_b   = 8'(b_reg >> sh);
        if (sub_op) s_b = ~s_b;
        s_cin = (cnt == '0) ? cin0 : c_run;
    end

    byte_slice_adder u_slice (
        .a       (s_a),
        .b       (s_b),
        .cin     (s_cin),
        .sum     (s_sum),
        .cout    (s_cout),
        .msb_cin (s_c7)
    );

    // Merge the slice into the result and accumulate the all-zero test.
    always_comb begin
        res_next  = (res_reg & ~(BYTE_MASK << sh)) | (WIDTH'(s_sum) << sh);
        z_now     = ((cnt == '0) || zacc) && (s_sum == 8'h00);
        cout_fin  = s_cout;
        c7_fin    = s_c7;
        calc_done = last_byte;
    end

    // Carry and zero state carried from one slice to the next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_run <= 1'b0;
            zacc  <= 1'b0;
        end else if (state == CALC) begin
            c_run <= s_cout;
            zacc  <= z_now;
        end
    end
`else
    logic [BYTES:0]   chain;
    logic [BYTES-1:0] msb_c;
    logic [WIDTH-1:0] b_eff, full_sum;

    assign b_eff    = sub_op ? ~b_reg : b_reg;
    assign chain[0] = cin0;

    for (genvar i = 0; i < BYTES; i++) begin : g_chain
        byte_slice_adder u_slice (
            .a       (a_reg[8*i +: 8]),
            .b       (b_eff[8*i +: 8]),
            .cin     (chain[i]),
            .sum     (full_sum[8*i +: 8]),
            .cout    (chain[i+1]),
            .msb_cin (msb_c[i])
        );
    end

    // Whole result is available in one cycle.
    always_comb begin
        res_next  = full_sum;
        z_now     = (full_sum == '0);
        cout_fin  = chain[BYTES];
        c7_fin    = msb_c[BYTES-1];
        calc_done = 1'b1;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD_A;
        else        state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && last_byte) next_state = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && last_byte) next_state = ARMED;
            end
            ARMED: begin
                if (start) next_state = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (calc_done) next_state = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && last_out) next_state = LOAD_A;
            end
            default: next_state = LOAD_A;
        endcase
    end

    // Operand capture, byte counter, result and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (in_valid) begin
                    a_reg <= (a_reg & ~(BYTE_MASK << sh)) | (WIDTH'(in_data) << sh);
                    cnt   <= last_byte ? '0 : cnt + CW'(1);
                end
                LOAD_B: if (in_valid) begin
                    b_reg <= (b_reg & ~(BYTE_MASK << sh)) | (WIDTH'(in_data) << sh);
                    cnt   <= last_byte ? '0 : cnt + CW'(1);
                end
                ARMED: if (start) begin
                    op_q <= op_e'(op);
                    cnt  <= '0;
                end
                CALC: begin
                    res_reg <= res_next;
                    cnt     <= calc_done ? '0 : cnt + CW'(1);
                    if (calc_done) begin
                        carry_q <= cout_fin;
                        ovf_q   <= c7_fin ^ cout_fin;
                        zero_q  <= z_now;
                    end
                end
                DRAIN: if (out_ready) begin
                    cnt <= last_out ? '0 : cnt + CW'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Status byte layout.
    always_comb begin
        status             = 8'h00;
        status[STAT_CARRY] = carry_q;
        status[STAT_OVF]   = ovf_q;
        status[STAT_ZERO]  = zero_q;
    end

    assign out_data = last_out ? status : 8'(res_reg >> sh);
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serdes_arith_unit.sv
// tb_serdes_arith_unit: randomized self-checking bench with an arithmetic
// reference model and a per-cycle output monitor.
module tb_serdes_arith_unit;

    localparam int WIDTH = 32;
    localparam int BYTES = WIDTH / 8;
`ifdef SERDES_ARITH_FULL_ADDER_EN
    localparam int BUSY_EXP = 1;
`else
    localparam int BUSY_EXP = BYTES;
`endif

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, start, busy;
    logic       out_valid, out_ready, carry, overflow, zero;
    logic [7:0] in_data, out_data;
    logic [1:0] op;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  exp_q[$];
    logic [2:0]  exp_flags;
    logic        model_carry;
    logic [63:0] mask;

    serdes_arith_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .op(op), .start(start), .busy(busy),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic and two's-complement sign rules.
    task automatic model_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] r, output logic [2:0] st);
        logic [64:0] full;
        logic [63:0] aa, bb;
        logic        cin, c, v;
        aa   = a & mask;
        bb   = o[0] ? (~b & mask) : (b & mask);
        cin  = o[1] ? model_carry : o[0];
        full = {1'b0, aa} + {1'b0, bb} + {64'b0, cin};
        r    = full[63:0] & mask;
        c    = full[WIDTH];
        v    = (aa[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != aa[WIDTH-1]);
        st   = {(r == 64'd0), v, c};
        model_carry = c;
    endtask

    // Output monitor: every valid output cycle must show the expected head byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            check("in_ready_in_drain", in_ready, 1'b0);
            check("busy_in_drain", busy, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                check("out_data", out_data, exp_q[0]);
                check("flags", {zero, overflow, carry}, exp_flags);
                if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
        op = 2'b00; out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_carry = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int   g;
        logic rdy;
        // Idle gaps carry spurious start pulses that must be ignored outside ARMED.
        repeat ($urandom_range(0, 2)) begin
            start = 1'($urandom_range(0, 1));
            op    = 2'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b1; in_data = d; g = 0; rdy = 1'b0;
        while (!rdy && g < 50) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1; g++;
        end
        in_valid = 1'b0;
        check("in_ready_wait", rdy, 1'b1);
    endtask

    task automatic load(input logic [63:0] v);
        for (int i = 0; i < BYTES; i++) send_byte(v[8*i +: 8]);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          input int mode, input bit pin,
                          input logic [63:0] lit_r, input logic [7:0] lit_st);
        logic [63:0] r;
        logic [2:0]  st;
        int          n, guard, stall;
        model_op(o, a, b, r, st);
        if (pin) begin
            check("pin_model_res", r, lit_r);
            check("pin_model_stat", {61'b0, st}, lit_st);
        end
        load(a);
        load(b);
        for (int i = 0; i < BYTES; i++) exp_q.push_back(r[8*i +: 8]);
        exp_q.push_back({5'b0, st});
        exp_flags = st;
        op = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom);
        n = 0; guard = 0;
        @(negedge clk);
        while (busy === 1'b1 && guard < 100) begin
            n++; guard++;
            @(negedge clk);
        end
        check("busy_cycles", n, BUSY_EXP);
        guard = 0; stall = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            @(posedge clk); #1; guard++;
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if ((BYTES + 1 - exp_q.size()) == 2 && stall < 5) begin
                out_ready = 1'b0; stall++;
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = 8'($urandom);
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, exp_q[0]);
            end else begin
                out_ready = 1'b1; in_valid = 1'b0;
            end
        end
        out_ready = 1'b0; in_valid = 1'b0;
        check("drain_done", exp_q.size(), 0);
        check("in_ready_after_drain", in_ready, 1'b1);
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = 64'd1 << (WIDTH - 1);
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v & mask;
    endfunction

    initial begin
        mask = (WIDTH == 64) ? '1 : ((64'd1 << WIDTH) - 64'd1);
        do_reset();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {zero, overflow, carry}, 3'b000);
        @(posedge clk); #1;

        run_op(2'b00, 64'h0000_00FF, 64'h1, 0, 1'b1, 64'h0000_0100, 8'h00);
        run_op(2'b00, 64'hFFFF_FFFF, 64'h1, 1, 1'b1, 64'h0000_0000, 8'h05);
        run_op(2'b10, 64'h0, 64'h0, 0, 1'b1, 64'h0000_0001, 8'h00);
        run_op(2'b01, 64'h8000_0000, 64'h1, 2, 1'b1, 64'h7FFF_FFFF, 8'h03);

        for (int k = 0; k < 40; k++)
            run_op(2'($urandom), rand_operand(), rand_operand(),
                   int'($urandom_range(0, 2)), 1'b0, 64'h0, 8'h00);

        // Reset during CALC after setting the sticky carry.
        run_op(2'b00, 64'hFFFF_FFFF, 64'h1, 0, 1'b1, 64'h0, 8'h05);
        load(64'h5);
        load(64'h6);
        op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (BUSY_EXP > 1) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_carry", carry, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1; model_carry = 1'b0;
        run_op(2'b00, 64'h3, 64'h4, 0, 1'b1, 64'h7, 8'h00);

        do_reset();
        run_op(2'b10, 64'h0, 64'h0, 1, 1'b1, 64'h0, 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
